uart_rx_controller: RTL and testbench
=====================================

UART_RX_CONTROLLER -- requirements
Module: uart_rx_controller

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, serial bit rate; 8N1 framing.
REQ-003 Parameter TIMEOUT_CYCLES, default 5_000_000, idle-line abort limit; used only with UART_RX_TIMEOUT_EN.
REQ-004 clk  in  1  single system clock; all logic on its rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 RX  in  1  serial input, idle high; asynchronous to clk.
REQ-007 start  in  1  level from a button or controller; a rising edge arms a frame capture.
REQ-008 base_address  in  25  RAM word address of the first 128-bit word; sampled on the accepted start edge.
REQ-009 wr_ack  in  1  RAM arbiter accepts the current write; single-cycle pulse.
REQ-010 wr_req  out  1  write request, held high until wr_ack.
REQ-011 wr_address  out  25  RAM address of the pending write.
REQ-012 wr_data  out  128  pending write word.
REQ-013 done  out  1  one-cycle pulse when the frame is complete.
REQ-014 overrun  out  1  sticky flag: a word was lost.
REQ-015 timeout_err  out  1  sticky flag: capture aborted on an idle line.
REQ-016 busy_led  out  1  active-low busy indicator (equals ~busy).

Function
REQ-017 uart_rx SHALL synchronise RX with 2 flops, detect the start bit, sample each bit at mid-bit using CLK_HZ/BAUD, and emit rx_data[7:0] with a one-cycle rx_valid at the stop bit.
REQ-018 A frame with a low stop bit SHALL be discarded (no rx_valid).
REQ-019 FSM states SHALL be IDLE, RECV, FLUSH, DONE.
REQ-020 IDLE: start high with the registered start low SHALL latch base_address, clear word_count, byte_index, overrun and timeout_err, set busy, and go to RECV; rx_valid in IDLE SHALL be ignored.
REQ-021 A start edge outside IDLE SHALL be ignored.
REQ-022 RECV: each rx_valid SHALL write rx_data into byte lane byte_index of the assembly register.
  - byte 0 goes to [7:0], byte 15 to [127:120] (LSB-first, matching the transmit order).
  - byte_index SHALL then increment, 4 bits, wrapping 15 to 0.
REQ-023 On byte 15 with wr_req low, the assembled word SHALL load into wr_data the next cycle, with wr_req high the same cycle.
REQ-024 On byte 15 with wr_req high, the word SHALL be dropped and overrun set; word_count SHALL be unchanged.
REQ-025 wr_req SHALL fall the cycle after wr_ack; on wr_ack, wr_address SHALL advance by 4 and word_count (18 bits) SHALL increment.
REQ-026 When the byte that completes word 0x9600 is written, the FSM SHALL go to FLUSH.
REQ-027 FLUSH: when wr_ack arrives for the final word, the FSM SHALL go to DONE.
REQ-028 If overrun occurred, the frame SHALL be incomplete and RECV SHALL continue until 0x9600 words are acked.
REQ-029 DONE: done SHALL pulse one cycle, busy SHALL clear, and the FSM SHALL return to IDLE.
REQ-030 wr_ack while wr_req is low SHALL be ignored.

Reset
REQ-031 Asserting rst_n low at any time SHALL force:
  - wr_req=0, wr_address=0, wr_data=0, done=0, overrun=0, timeout_err=0, busy_led=1;
  - FSM=IDLE, byte_index=0, word_count=0.
REQ-032 A partial byte, partial word or pending write SHALL be dropped without an ack wait; uart_rx SHALL return to hunting for a start bit.

Configuration
REQ-033 With UART_RX_TIMEOUT_EN defined:
  - in RECV, a counter SHALL clear on each rx_valid and otherwise count when byte_index!=0 or word_count!=0;
  - when it reaches TIMEOUT_CYCLES, the block SHALL set timeout_err, drop wr_req, clear busy, and go to IDLE.
REQ-034 Without UART_RX_TIMEOUT_EN, no timeout counter SHALL be built, timeout_err SHALL be tied 0, and RECV SHALL wait indefinitely.

Structure
REQ-035 Shared package uart_pkg SHALL hold FRAME_WORDS=18'h9600, ADDR_STEP=4, BYTES_PER_WORD=16 and the FSM state encoding; uart_controller SHALL use the same constants.
REQ-036 Bit-level reception SHALL be the sub-module uart_rx (clk, rst_n, RX -> rx_data, rx_valid); the word/RAM logic stays in uart_rx_controller.

Verification
REQ-037 Reset held, RX idle -> all outputs at their REQ-031 values; start edge, base 0x25800, 16 bytes 0x00..0x0F -> one wr_req, wr_address 0x25800, wr_data 0x0F0E..0100.
REQ-038 Ack 1 cycle after each req, full 0x9600-word frame -> last wr_address 0x25800+4*0x95FF, single done pulse, busy_led back to 1, overrun 0.
REQ-039 Hold wr_ack low for 200 byte times -> overrun=1, wr_address unchanged until ack; a second start ignored while busy.
REQ-040 Byte with stop bit forced low -> no rx_valid, byte_index unchanged; next good byte lands in the same lane.
REQ-041 Reset pulsed mid-word (byte_index=7, wr_req high) -> wr_req 0 immediately, FSM IDLE; a new start captures from byte lane 0.
REQ-042 With UART_RX_TIMEOUT_EN and TIMEOUT_CYCLES=1000, stop RX after 5 bytes -> timeout_err=1 after 1000 cycles, FSM IDLE, no done pulse.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg -- constants and state encodings shared by the UART receive path.
//   FRAME_WORDS    : number of 128-bit words in a complete frame
//   ADDR_STEP      : RAM address increment per written word
//   BYTES_PER_WORD : bytes assembled into one 128-bit word
package uart_pkg;

  localparam logic [17:0] FRAME_WORDS    = 18'h9600;
  localparam logic [24:0] ADDR_STEP      = 25'd4;
  localparam int unsigned BYTES_PER_WORD = 16;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    FLUSH,
    DONE
  } ctrl_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// uart_rx -- 8N1 bit-level receiver.
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   RX       : serial input, idle high, asynchronous to clk
//   rx_data  : received byte (valid with rx_valid)
//   rx_valid : one-cycle pulse at mid stop bit when the stop bit is high
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic [7:0] rx_data,
  output logic       rx_valid
);

  localparam int unsigned CPB = CLK_HZ / BAUD;
  localparam int unsigned CW  = $clog2(CPB + 1);
  localparam logic [CW-1:0] FULL = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);

  logic          sync1, sync2, prev;
  rx_state_t     state, next;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  always_comb begin
    next = state;
    case (state)
      // Falling edge only, so a low stop bit cannot be mistaken for a start bit.
      RX_IDLE:  if (prev && !sync2) next = RX_START;
      RX_START: if (cnt == HALF) next = sync2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (cnt == FULL && bit_idx == 3'd7) next = RX_STOP;
      RX_STOP:  if (cnt == FULL) next = RX_IDLE;
      default:  next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      prev     <= 1'b1;
      state    <= RX_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      sync1    <= RX;
      sync2    <= sync1;
      prev     <= sync2;
      state    <= next;
      rx_valid <= 1'b0;
      case (state)
        RX_IDLE: cnt <= '0;
        RX_START: begin
          bit_idx <= '0;
          cnt     <= (cnt == HALF) ? '0 : cnt + 1'b1;
        end
        RX_DATA: begin
          if (cnt == FULL) begin
            cnt     <= '0;
            shreg   <= {sync2, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == FULL) begin
            cnt <= '0;
            if (sync2) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_controller.sv
// uart_rx_controller -- assembles received UART bytes into 128-bit words and
// writes them to RAM through a req/ack handshake.
//   clk, rst_n   : system clock, asynchronous active-low reset
//   RX           : serial input
//   start        : rising edge arms a frame capture (ignored while busy)
//   base_address : first RAM word address, sampled on the accepted start
//   wr_ack       : arbiter accepted the pending write
//   wr_req/wr_address/wr_data : pending write
//   done         : one-cycle pulse when the frame is complete
//   overrun      : sticky, a word was dropped while a write was pending
//   timeout_err  : sticky, capture aborted on an idle line
//   busy_led     : active-low busy
// Optional feature: define UART_RX_TIMEOUT_EN to build the idle-line timeout.
// FRAME_LEN defaults to the package FRAME_WORDS.
module uart_rx_controller
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 50_000_000,
  parameter int unsigned BAUD           = 115200,
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000,
  parameter logic [17:0] FRAME_LEN      = FRAME_WORDS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         RX,
  input  logic         start,
  input  logic [24:0]  base_address,
  input  logic         wr_ack,
  output logic         wr_req,
  output logic [24:0]  wr_address,
  output logic [127:0] wr_data,
  output logic         done,
  output logic         overrun,
  output logic         timeout_err,
  output logic         busy_led
);

  logic [7:0]   rx_data;
  logic         rx_valid;
  ctrl_state_t  state, next;
  logic         start_q, start_rise, busy, timeout_hit, last_byte;
  logic [3:0]   byte_index;
  logic [17:0]  word_count;
  logic [127:0] asm_word;

  uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .RX       (RX),
    .rx_data  (rx_data),
    .rx_valid (rx_valid)
  );

  assign start_rise = start & ~start_q;
  assign last_byte  = rx_valid && (byte_index == 4'(BYTES_PER_WORD - 1));
  assign busy_led   = ~busy;

`ifdef UART_RX_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt;
  logic          counting, to_flag;

  assign counting    = (byte_index != '0) || (word_count != '0);
  assign timeout_hit = (state == RECV) && !rx_valid && counting &&
                       (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign timeout_err = to_flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
      to_flag  <= 1'b0;
    end else begin
      if (state == IDLE && start_rise) to_flag <= 1'b0;
      else if (timeout_hit)            to_flag <= 1'b1;
      if (state != RECV || rx_valid || timeout_hit) idle_cnt <= '0;
      else if (counting)                            idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next;
  end

  always_comb begin
    next = state;
    done = 1'b0;
    case (state)
      IDLE: if (start_rise) next = RECV;
      RECV: begin
        if (timeout_hit) next = IDLE;
        // Only a word that is actually loaded counts toward the frame; with
        // wr_req low every earlier word has been acked, so word_count is exact.
        else if (last_byte && !wr_req && word_count == FRAME_LEN - 18'd1)
          next = FLUSH;
      end
      FLUSH: if (wr_req && wr_ack) next = DONE;
      DONE: begin
        done = 1'b1;
        next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q    <= 1'b0;
      busy       <= 1'b0;
      wr_req     <= 1'b0;
      wr_address <= '0;
      wr_data    <= '0;
      overrun    <= 1'b0;
      byte_index <= '0;
      word_count <= '0;
      asm_word   <= '0;
    end else begin
      start_q <= start;
      if (state == IDLE && start_rise) begin
        wr_address <= base_address;
        word_count <= '0;
        byte_index <= '0;
        overrun    <= 1'b0;
        busy       <= 1'b1;
      end else if (timeout_hit) begin
        wr_req <= 1'b0;
        busy   <= 1'b0;
      end else begin
        if (wr_req && wr_ack) begin
          wr_req     <= 1'b0;
          wr_address <= wr_address + ADDR_STEP;
          word_count <= word_count + 18'd1;
        end
        if (state == RECV && rx_valid) begin
          asm_word[{byte_index, 3'b000} +: 8] <= rx_data;
          byte_index <= byte_index + 4'd1;
          if (last_byte) begin
            if (wr_req) begin
              overrun <= 1'b1;
            end else begin
              wr_data <= {rx_data, asm_word[119:0]};
              wr_req  <= 1'b1;
            end
          end
        end
        if (state == DONE) busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_controller.sv
// tb_uart_rx_controller -- self-checking bench for uart_rx_controller.
// Serial bytes are generated at 8 clocks per bit; the expected RAM writes are
// built from the byte stream (16 bytes per word, first byte lowest) and the
// frame/overrun rules, and compared with the writes the arbiter model acks.
module tb_uart_rx_controller;

  localparam int unsigned CLK_HZ  = 1_000_000;
  localparam int unsigned BAUD    = 125_000;
  localparam int unsigned BIT     = CLK_HZ / BAUD;
  localparam int unsigned TIMEOUT = 1000;
  localparam int unsigned NWORDS  = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         RX = 1'b1;
  logic         start = 1'b0;
  logic [24:0]  base_address = '0;
  logic         wr_ack = 1'b0;
  logic         wr_req, done, overrun, timeout_err, busy_led;
  logic [24:0]  wr_address;
  logic [127:0] wr_data;

  int n_checks = 0;
  int n_fail   = 0;

  bit           ack_en = 1'b0;
  int           done_count = 0;
  logic [24:0]  obs_addr[$];
  logic [127:0] obs_data[$];

  uart_rx_controller #(
    .CLK_HZ         (CLK_HZ),
    .BAUD           (BAUD),
    .TIMEOUT_CYCLES (TIMEOUT),
    .FRAME_LEN      (18'(NWORDS))
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .RX           (RX),
    .start        (start),
    .base_address (base_address),
    .wr_ack       (wr_ack),
    .wr_req       (wr_req),
    .wr_address   (wr_address),
    .wr_data      (wr_data),
    .done         (done),
    .overrun      (overrun),
    .timeout_err  (timeout_err),
    .busy_led     (busy_led)
  );

  always #5 clk = ~clk;

  // Arbiter model: acks one cycle after it sees a request, logs what it accepted.
  always @(negedge clk) begin
    if (wr_ack) wr_ack = 1'b0;
    else if (ack_en && wr_req) begin
      wr_ack = 1'b1;
      obs_addr.push_back(wr_address);
      obs_data.push_back(wr_data);
    end
    if (done) done_count++;
  end

  function automatic logic [127:0] pack_word(input logic [7:0] q[$], input int off);
    logic [127:0] w = '0;
    for (int i = 0; i < 16; i++) w = w | (128'(q[off + i]) << (8 * i));
    return w;
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    @(negedge clk);
    RX = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (BIT) @(negedge clk);
    end
    RX = stop_ok;
    repeat (BIT) @(negedge clk);
    RX = 1'b1;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic pulse_start(input logic [24:0] base);
    @(negedge clk);
    base_address = base;
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    ack_en = 1'b0;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_done(input int target, input string name);
    int cyc = 0;
    while (done_count < target && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (done_count !== target) begin
      n_fail++;
      $display("FAIL %s: done pulses %0d, expected %0d", name, done_count, target);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if ({wr_req, done, overrun, timeout_err, busy_led} !== 5'b00001) begin
      n_fail++;
      $display("FAIL reset_flags: req/done/ovr/to/led %b, expected 00001",
               {wr_req, done, overrun, timeout_err, busy_led});
    end
    n_checks++;
    if (wr_address !== 25'd0 || wr_data !== 128'd0) begin
      n_fail++;
      $display("FAIL reset_bus: addr %h data %h, expected 0 0", wr_address, wr_data);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // First word with bytes 00..0F held pending, then the rest of the frame acked.
  task automatic test_full_frame();
    logic [7:0] bytes[$];
    int d0 = done_count;
    int o0 = obs_addr.size();
    pulse_start(25'h25800);
    n_checks++;
    if (busy_led !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_after_start: busy_led %b, expected 0", busy_led);
    end
    for (int i = 0; i < 16; i++) begin
      bytes.push_back(8'(i));
      send_byte(8'(i), 1'b1);
    end
    n_checks++;
    if (wr_req !== 1'b1 || wr_address !== 25'h25800) begin
      n_fail++;
      $display("FAIL first_req: req %b addr %h, expected 1 25800", wr_req, wr_address);
    end
    n_checks++;
    if (wr_data !== 128'h0F0E0D0C0B0A09080706050403020100) begin
      n_fail++;
      $display("FAIL first_data: %h, expected 0f0e..0100", wr_data);
    end
    ack_en = 1'b1;
    for (int i = 16; i < 16 * NWORDS; i++) begin
      bytes.push_back(8'($urandom));
      send_byte(bytes[i], 1'b1);
    end
    wait_done(d0 + 1, "frame_done");
    repeat (4) @(negedge clk);
    n_checks++;
    if (obs_addr.size() - o0 != NWORDS) begin
      n_fail++;
      $display("FAIL frame_writes: %0d writes, expected %0d", obs_addr.size() - o0, NWORDS);
    end else begin
      for (int k = 0; k < NWORDS; k++) begin
        n_checks++;
        if (obs_addr[o0 + k] !== 25'h25800 + 25'(4 * k) || obs_data[o0 + k] !== pack_word(bytes, 16 * k)) begin
          n_fail++;
          $display("FAIL frame_word%0d: addr %h data %h, expected %h %h", k, obs_addr[o0 + k],
                   obs_data[o0 + k], 25'h25800 + 25'(4 * k), pack_word(bytes, 16 * k));
        end
      end
    end
    n_checks++;
    if (done_count !== d0 + 1 || busy_led !== 1'b1 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_end: done %0d led %b ovr %b, expected %0d 1 0",
               done_count - d0, busy_led, overrun, 1);
    end
  endtask

  // Word 1 is dropped while word 0 is still pending; frame needs NWORDS acked words.
  task automatic test_overrun();
    logic [7:0] bytes[$];
    logic [24:0] base = 25'($urandom) & ~25'h3;
    int d0, o0;
    do_reset();
    d0 = done_count;
    o0 = obs_addr.size();
    pulse_start(base);
    for (int i = 0; i < 32; i++) begin
      bytes.push_back(8'($urandom));
      send_byte(bytes[i], 1'b1);
    end
    n_checks++;
    if (overrun !== 1'b1 || wr_address !== base || wr_req !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_flag: ovr %b addr %h req %b, expected 1 %h 1", overrun, wr_address, wr_req, base);
    end
    pulse_start(base ^ 25'h100000);
    n_checks++;
    if (wr_address !== base || busy_led !== 1'b0) begin
      n_fail++;
      $display("FAIL start_while_busy: addr %h led %b, expected %h 0", wr_address, busy_led, base);
    end
    ack_en = 1'b1;
    for (int i = 32; i < 16 * (NWORDS + 1); i++) begin
      bytes.push_back(8'($urandom));
      send_byte(bytes[i], 1'b1);
    end
    wait_done(d0 + 1, "overrun_done");
    repeat (4) @(negedge clk);
    n_checks++;
    if (obs_addr.size() - o0 != NWORDS) begin
      n_fail++;
      $display("FAIL overrun_writes: %0d writes, expected %0d", obs_addr.size() - o0, NWORDS);
    end else begin
      for (int k = 0; k < NWORDS; k++) begin
        int src = (k == 0) ? 0 : 16 * (k + 1);
        n_checks++;
        if (obs_addr[o0 + k] !== base + 25'(4 * k) || obs_data[o0 + k] !== pack_word(bytes, src)) begin
          n_fail++;
          $display("FAIL overrun_word%0d: addr %h data %h, expected %h %h", k, obs_addr[o0 + k],
                   obs_data[o0 + k], base + 25'(4 * k), pack_word(bytes, src));
        end
      end
    end
    n_checks++;
    if (overrun !== 1'b1 || busy_led !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_sticky: ovr %b led %b, expected 1 1", overrun, busy_led);
    end
  endtask

  task automatic test_bad_stop();
    logic [7:0] good[$];
    int o0;
    do_reset();
    o0 = obs_addr.size();
    ack_en = 1'b1;
    pulse_start(25'h00040);
    for (int i = 0; i < 17; i++) begin
      logic [7:0] b = 8'($urandom);
      if (i == 3) send_byte(b, 1'b0);
      else begin
        good.push_back(b);
        send_byte(b, 1'b1);
      end
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (obs_addr.size() - o0 != 1) begin
      n_fail++;
      $display("FAIL bad_stop_writes: %0d writes, expected 1", obs_addr.size() - o0);
    end else begin
      n_checks++;
      if (obs_data[o0] !== pack_word(good, 0) || obs_addr[o0] !== 25'h00040) begin
        n_fail++;
        $display("FAIL bad_stop_word: addr %h data %h, expected 00040 %h", obs_addr[o0], obs_data[o0], pack_word(good, 0));
      end
    end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] bytes[$];
    int o0;
    do_reset();
    pulse_start(25'h01000);
    for (int i = 0; i < 23; i++) send_byte(8'($urandom), 1'b1);
    n_checks++;
    if (wr_req !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_word_pending: req %b, expected 1", wr_req);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({wr_req, overrun, busy_led, done} !== 4'b0010 || wr_address !== 25'd0 || wr_data !== 128'd0) begin
      n_fail++;
      $display("FAIL mid_word_reset: req/ovr/led/done %b addr %h data %h, expected 0010 0 0",
               {wr_req, overrun, busy_led, done}, wr_address, wr_data);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    o0 = obs_addr.size();
    ack_en = 1'b1;
    pulse_start(25'h02000);
    for (int i = 0; i < 16; i++) begin
      bytes.push_back(8'($urandom));
      send_byte(bytes[i], 1'b1);
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (obs_addr.size() - o0 != 1) begin
      n_fail++;
      $display("FAIL restart_writes: %0d writes, expected 1", obs_addr.size() - o0);
    end else begin
      n_checks++;
      if (obs_addr[o0] !== 25'h02000 || obs_data[o0] !== pack_word(bytes, 0)) begin
        n_fail++;
        $display("FAIL restart_word: addr %h data %h, expected 02000 %h", obs_addr[o0], obs_data[o0], pack_word(bytes, 0));
      end
    end
  endtask

  task automatic test_timeout();
    int d0;
    int cyc = 0;
    do_reset();
    d0 = done_count;
    ack_en = 1'b1;
    pulse_start(25'h00100);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b1);
    repeat (900) @(negedge clk);
    n_checks++;
    if (timeout_err !== 1'b0 || busy_led !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_early: to %b led %b, expected 0 0", timeout_err, busy_led);
    end
`ifdef UART_RX_TIMEOUT_EN
    while (timeout_err !== 1'b1 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (timeout_err !== 1'b1 || busy_led !== 1'b1 || wr_req !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_abort: to %b led %b req %b, expected 1 1 0", timeout_err, busy_led, wr_req);
    end
`else
    repeat (600) @(negedge clk);
    n_checks++;
    if (timeout_err !== 1'b0 || busy_led !== 1'b0) begin
      n_fail++;
      $display("FAIL no_timeout: to %b led %b cycles %0d, expected 0 0", timeout_err, busy_led, cyc);
    end
`endif
    n_checks++;
    if (done_count !== d0) begin
      n_fail++;
      $display("FAIL timeout_no_done: done pulses %0d, expected 0", done_count - d0);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_overrun();
    test_bad_stop();
    test_reset_mid_word();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
